// File: rtl/o_coef_gen.sv
// Per-row online-softmax coefficient generator: exp2(m_old - m_new) rescale or 1/l
// normalisation, LANES rows per pass through an EXP -> MUL -> restoring-DIV pipeline.
module o_coef_gen #(
  parameter int D_W   = 8,
  parameter int TIL   = 16,
  parameter int LANES = 4,
  parameter int FRAC  = 5,
  parameter int LOG2E = 46
) (
  input  logic                      I_CLK,
  input  logic                      I_RST_N,
  input  logic                      I_VLD,
  output logic                      O_RDY,
  input  logic                      I_MODE,
  input  logic [TIL-1:0][2*D_W-1:0] I_LI_OLD,
  input  logic [TIL-1:0][D_W-1:0]   I_MI_OLD,
  input  logic [TIL-1:0][2*D_W-1:0] I_LI_NEW,
  input  logic [TIL-1:0][D_W-1:0]   I_MI_NEW,
  output logic                      O_VLD,
  input  logic                      I_RDY,
  output logic [TIL-1:0][D_W-1:0]   O_COEFFICIENT,
  output logic [TIL-1:0]            O_SAT,
  output logic [TIL-1:0]            O_DIV0
);
  // Handshakes: a request transfers on a rising edge with I_VLD & O_RDY; a result
  // transfers on a rising edge with O_VLD & I_RDY, and O_VLD/data hold until then.
  localparam int P   = TIL / LANES;
  localparam int PW  = (P > 1) ? $clog2(P) : 1;
  localparam int RW  = (TIL > 1) ? $clog2(TIL) : 1;
  localparam int QW  = D_W - 1;
  localparam int CW  = (QW > 1) ? $clog2(QW) : 1;
  localparam int LW  = 2 * D_W;
  localparam int PRW = 4 * D_W;
  localparam int TW  = D_W + 33;
  localparam logic signed [TW-1:0] K_LOG2E = TW'(LOG2E);
  localparam logic signed [TW-1:0] N_SAT   = TW'(D_W);
  localparam logic [D_W-1:0]       C_MAX   = {1'b0, {QW{1'b1}}};

  typedef enum logic [2:0] {IDLE, EXP, MUL, DIV, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       rdy_q, rdy_d, vld_q, vld_d, mode_q, mode_d;
  logic [TIL-1:0][LW-1:0]     li_old_q, li_old_d, li_new_q, li_new_d;
  logic [TIL-1:0][D_W-1:0]    mi_old_q, mi_old_d, mi_new_q, mi_new_d;
  logic [PW-1:0]              pass_q, pass_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][LW-1:0]   e_q, e_d;
  logic [LANES-1:0][PRW-1:0]  rem_q, rem_d, den_q, den_d;
  logic [LANES-1:0][QW-1:0]   quo_q, quo_d;
  logic [LANES-1:0]           sat_q, sat_d, dz_q, dz_d;
  logic [TIL-1:0][D_W-1:0]    coef_q, coef_d;
  logic [TIL-1:0]             osat_q, osat_d, odz_q, odz_d;

  logic [RW-1:0]        row    [LANES];
  logic signed [D_W:0]  d_s    [LANES];
  logic signed [TW-1:0] t_s    [LANES];
  logic signed [TW-1:0] n_s    [LANES];
  logic [LW-1:0]        base   [LANES];
  logic [LW-1:0]        e_calc [LANES];
  logic [PRW-1:0]       p_calc [LANES];
  logic [QW-1:0]        quo_nx [LANES];
  logic [LANES-1:0]     ovf_calc, dz_calc, qbit;

  // Per-lane datapath: exp2 split into integer shift n and fraction f of t = d*log2(e).
  always_comb begin
    ovf_calc = '0;
    dz_calc  = '0;
    qbit     = '0;
    for (int l = 0; l < LANES; l++) begin
      row[l]   = RW'(int'(pass_q) * LANES + l);
      d_s[l]   = $signed({mi_old_q[row[l]][D_W-1], mi_old_q[row[l]]})
               - $signed({mi_new_q[row[l]][D_W-1], mi_new_q[row[l]]});
      t_s[l]   = (TW'(d_s[l]) * K_LOG2E) >>> FRAC;
      n_s[l]   = t_s[l] >>> FRAC;
      base[l]  = LW'({1'b1, t_s[l][FRAC-1:0]});
      if (n_s[l] >= N_SAT)
        e_calc[l] = '1;
      else if (!n_s[l][TW-1])
        e_calc[l] = base[l] << n_s[l];
      else
        e_calc[l] = base[l] >> (-n_s[l]);
      p_calc[l]   = mode_q ? (PRW'(1) << (2 * FRAC))
                           : PRW'(li_old_q[row[l]]) * PRW'(e_q[l]);
      dz_calc[l]  = (li_new_q[row[l]] == '0);
      ovf_calc[l] = (p_calc[l] >= (PRW'(li_new_q[row[l]]) << (D_W - 1)));
      qbit[l]     = (rem_q[l] >= den_q[l]);
      quo_nx[l]   = QW'({quo_q[l], qbit[l]});
    end
  end

  always_comb begin
    state_d  = state_q;
    rdy_d    = rdy_q;
    vld_d    = vld_q;
    mode_d   = mode_q;
    li_old_d = li_old_q;
    li_new_d = li_new_q;
    mi_old_d = mi_old_q;
    mi_new_d = mi_new_q;
    pass_d   = pass_q;
    cnt_d    = cnt_q;
    e_d      = e_q;
    rem_d    = rem_q;
    den_d    = den_q;
    quo_d    = quo_q;
    sat_d    = sat_q;
    dz_d     = dz_q;
    coef_d   = coef_q;
    osat_d   = osat_q;
    odz_d    = odz_q;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (I_VLD && rdy_q) begin
          rdy_d    = 1'b0;
          mode_d   = I_MODE;
          li_old_d = I_LI_OLD;
          li_new_d = I_LI_NEW;
          mi_old_d = I_MI_OLD;
          mi_new_d = I_MI_NEW;
          pass_d   = '0;
          state_d  = EXP;
        end
      end
      EXP: begin
        for (int l = 0; l < LANES; l++) e_d[l] = e_calc[l];
        state_d = MUL;
      end
      MUL: begin
        for (int l = 0; l < LANES; l++) begin
          rem_d[l] = p_calc[l];
          den_d[l] = PRW'(li_new_q[row[l]]) << (D_W - 2);
          quo_d[l] = '0;
          dz_d[l]  = dz_calc[l];
          sat_d[l] = ovf_calc[l] & ~dz_calc[l];
        end
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        for (int l = 0; l < LANES; l++) begin
          rem_d[l] = qbit[l] ? (rem_q[l] - den_q[l]) : rem_q[l];
          den_d[l] = den_q[l] >> 1;
          quo_d[l] = quo_nx[l];
        end
        if (cnt_q == CW'(QW - 1)) begin
          for (int l = 0; l < LANES; l++) begin
            coef_d[row[l]] = (sat_q[l] | dz_q[l]) ? C_MAX : {1'b0, quo_nx[l]};
            osat_d[row[l]] = sat_q[l];
            odz_d[row[l]]  = dz_q[l];
          end
          if (pass_q == PW'(P - 1)) begin
            state_d = DONE;
          end else begin
            pass_d  = pass_q + 1'b1;
            state_d = EXP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // One settle cycle in DONE before O_VLD rises; results are already registered.
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (I_RDY) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      vld_q    <= 1'b0;
      mode_q   <= 1'b0;
      li_old_q <= '0;
      li_new_q <= '0;
      mi_old_q <= '0;
      mi_new_q <= '0;
      pass_q   <= '0;
      cnt_q    <= '0;
      e_q      <= '0;
      rem_q    <= '0;
      den_q    <= '0;
      quo_q    <= '0;
      sat_q    <= '0;
      dz_q     <= '0;
      coef_q   <= '0;
      osat_q   <= '0;
      odz_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      mode_q   <= mode_d;
      li_old_q <= li_old_d;
      li_new_q <= li_new_d;
      mi_old_q <= mi_old_d;
      mi_new_q <= mi_new_d;
      pass_q   <= pass_d;
      cnt_q    <= cnt_d;
      e_q      <= e_d;
      rem_q    <= rem_d;
      den_q    <= den_d;
      quo_q    <= quo_d;
      sat_q    <= sat_d;
      dz_q     <= dz_d;
      coef_q   <= coef_d;
      osat_q   <= osat_d;
      odz_q    <= odz_d;
    end
  end

  assign O_RDY         = rdy_q;
  assign O_VLD         = vld_q;
  assign O_COEFFICIENT = coef_q;
  assign O_SAT         = osat_q;
  assign O_DIV0        = odz_q;

endmodule
